// File: rtl/cache_replacement_unit_if.sv
// cache_replacement_unit_if: access/status bundle between a cache controller and its replacement unit
interface cache_replacement_unit_if #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4
);
    localparam int SW = $clog2(NUM_SETS);
    localparam int LW = $clog2(NUM_WAYS);
    logic [SW-1:0] set;
    logic          hit;
    logic [LW-1:0] hit_way;
    logic          cru_enable;
    logic          fill_enable;
    logic          flush;
    logic [LW-1:0] replace_way;
    logic [LW-1:0] populate_way;
    logic          populated;
    logic [31:0]   hit_count;
    logic [31:0]   replace_count;
    modport master (
        output set, hit, hit_way, cru_enable, fill_enable, flush,
        input  replace_way, populate_way, populated, hit_count, replace_count
    );
    modport slave (
        input  set, hit, hit_way, cru_enable, fill_enable, flush,
        output replace_way, populate_way, populated, hit_count, replace_count
    );
endinterface

// File: rtl/cache_replacement_unit.sv
// cache_replacement_unit: per-set valid tracking and tree-PLRU victim selection; CACHE_REPLACEMENT_UNIT_PERF_EN adds hit/replace counters
module cache_replacement_unit #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4
) (
    input logic clk,
    input logic rst_n,
    cache_replacement_unit_if.slave bus
);
    localparam int LW = $clog2(NUM_WAYS);

    logic [NUM_WAYS-1:0] valid [NUM_SETS];
    logic [NUM_WAYS-2:0] plru [NUM_SETS];
    logic [NUM_WAYS-1:0] cur_valid;
    logic [NUM_WAYS-2:0] cur_plru;
    logic [LW-1:0]       victim_way;
    logic [LW-1:0]       free_way;
    logic                full;

    // Nodes are heap-ordered: node n has children 2n+1 (lower ways) and 2n+2 (upper ways).
    function automatic logic [LW-1:0] victim(input logic [NUM_WAYS-2:0] p);
        logic [LW-1:0] n;
        logic [LW-1:0] w;
        n = '0;
        w = '0;
        for (int l = 0; l < LW; l++) begin
            w = LW'({w, p[n]});
            n = LW'({n, 1'b0}) + LW'(1) + LW'(p[n]);
        end
        return w;
    endfunction

    function automatic logic [NUM_WAYS-2:0] touch(input logic [NUM_WAYS-2:0] p, input logic [LW-1:0] w);
        logic [NUM_WAYS-2:0] q;
        logic [LW-1:0]       n;
        logic [LW-1:0]       r;
        logic                b;
        q = p;
        n = '0;
        r = w;
        for (int l = 0; l < LW; l++) begin
            b    = r[LW-1];
            q[n] = ~b;
            r    = r << 1;
            n    = LW'({n, 1'b0}) + LW'(1) + LW'(b);
        end
        return q;
    endfunction

    assign cur_valid = valid[bus.set];
    assign cur_plru  = plru[bus.set];
    assign full      = &cur_valid;

    // Victim follows the PLRU pointers from the root of the selected set.
    always_comb victim_way = victim(cur_plru);

    // Lowest-index invalid way; stays 0 once the set is full.
    always_comb begin
        free_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--)
            if (!cur_valid[i]) free_way = LW'(i);
    end

    assign bus.replace_way  = victim_way;
    assign bus.populate_way = free_way;
    assign bus.populated    = full;

    // One update per edge, flush > replace > fill > hit; a fill into a full set still blocks the hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.flush) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                valid[i] <= '0;
                plru[i]  <= '0;
            end
        end else if (bus.cru_enable) begin
            plru[bus.set] <= touch(cur_plru, victim_way);
        end else if (bus.fill_enable) begin
            if (!full) begin
                valid[bus.set][free_way] <= 1'b1;
                plru[bus.set]            <= touch(cur_plru, free_way);
            end
        end else if (bus.hit) begin
            plru[bus.set] <= touch(cur_plru, bus.hit_way);
        end
    end

`ifdef CACHE_REPLACEMENT_UNIT_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] repl_cnt;
    logic        hit_app;
    logic        repl_app;

    assign hit_app  = bus.hit && !bus.flush && !bus.cru_enable && !bus.fill_enable;
    assign repl_app = bus.cru_enable && !bus.flush;

    // Saturating counters of applied hits and replacements; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            repl_cnt <= '0;
        end else begin
            if (hit_app && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            if (repl_app && repl_cnt != '1) repl_cnt <= repl_cnt + 32'd1;
        end
    end

    assign bus.hit_count     = hit_cnt;
    assign bus.replace_count = repl_cnt;
`else
    assign bus.hit_count     = '0;
    assign bus.replace_count = '0;
`endif
endmodule

// File: doc/cache_replacement_unit.md
CACHE_REPLACEMENT_UNIT -- requirements
Module: cache_replacement_unit

Interface
REQ-001 SHALL have parameter NUM_SETS, default 16, number of sets (power of 2, >=2).
REQ-002 SHALL have parameter NUM_WAYS, default 4, ways per set (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port set  input  $clog2(NUM_SETS)  set index of the current access.
REQ-006 SHALL have port hit  input  1  access to set hit way hit_way this cycle.
REQ-007 SHALL have port hit_way  input  $clog2(NUM_WAYS)  way that hit.
REQ-008 SHALL have port cru_enable  input  1  replacement of replace_way in set this cycle.
REQ-009 SHALL have port fill_enable  input  1  populate write of populate_way in set this cycle.
REQ-010 SHALL have port flush  input  1  invalidate all sets.
REQ-011 SHALL have port replace_way  output  $clog2(NUM_WAYS)  PLRU victim of set.
REQ-012 SHALL have port populate_way  output  $clog2(NUM_WAYS)  lowest-index invalid way of set.
REQ-013 SHALL have port populated  output  1  all ways of set valid.
REQ-014 SHALL have ports hit_count, replace_count  output  32 each  performance counters (see Configuration).

Function
REQ-015 SHALL hold per set: NUM_WAYS valid bits and NUM_WAYS-1 tree-PLRU bits; all state in flops.
REQ-016 SHALL drive replace_way, populate_way, populated combinationally from set and current state (zero latency).
REQ-017 SHALL select victim by walking tree from root: bit 0 -> lower-index subtree, bit 1 -> upper subtree.
REQ-018 SHALL "touch" way w by setting every node on w's path to point away from w.
REQ-019 SHALL drive populate_way = 0 when populated = 1.
REQ-020 SHALL apply one update per rising edge with priority flush > cru_enable > fill_enable > hit.
REQ-021 flush: SHALL clear valid and PLRU bits of all sets in one cycle.
REQ-022 cru_enable: SHALL touch replace_way in set; valid bits unchanged.
REQ-023 fill_enable with populated=0: SHALL set valid[populate_way] and touch populate_way.
REQ-024 fill_enable with populated=1: SHALL be ignored (no state change).
REQ-025 hit: SHALL touch hit_way; SHALL not change valid bits.
REQ-026 SHALL make updated state visible on outputs the cycle after the update edge.
REQ-027 Lower-priority requests dropped under REQ-020 SHALL have no effect and SHALL not be counted.

Reset
REQ-028 rst_n low SHALL immediately clear all valid bits, PLRU bits and counters, independent of clk.
REQ-029 During/after reset SHALL output replace_way=0, populate_way=0, populated=0 for every set.
REQ-030 rst_n asserted mid-operation SHALL discard any update of that cycle.

Configuration
REQ-031 Macro CACHE_REPLACEMENT_UNIT_PERF_EN SHALL gate the performance counters.
REQ-032 With macro: hit_count increments on each applied hit, replace_count on each applied cru_enable; both saturate at 2^32-1; flush does not clear them.
REQ-033 Without macro: counters not instantiated; hit_count and replace_count tied to 0.

Verification
REQ-034 After reset, set=5 -> replace_way=0, populate_way=0, populated=0.
REQ-035 NUM_WAYS=4, four fill_enable to set 3 -> populate_way 0,1,2,3 in turn, then populated=1, populate_way=0.
REQ-036 Set 3 full, reset PLRU, hit way 0 -> replace_way=2; then hit way 2 -> replace_way=1.
REQ-037 cru_enable and fill_enable same cycle, set 3 -> only PLRU touch of replace_way; valid bits unchanged.
REQ-038 flush with hit same cycle after filling sets 0..15 -> all sets populated=0, replace_way=0; hit_count unchanged.
REQ-039 PERF_EN: 3 hits + 2 cru_enable -> hit_count=3, replace_count=2; rst_n low mid-cycle -> both 0 immediately.
